i2c_config_seq: RTL and testbench

- Boot-time configuration sequencer for the audio codec.
- Sits directly upstream of the I2C master. It walks an external register table of {reg_addr, data} words and issues one I2C write per entry over the master's write_valid/write_ready handshake.
- It detects completion of each frame, checks the master's NACK error flag, retries failed writes, and reports done or fail to the top-level bring-up logic.
- Runs on the 20 kHz I2C clock domain.

---
 rtl/i2c_config_seq_if.sv | 36 +++
 rtl/i2c_config_seq.sv | 176 +++++++++++++++++
 tb/tb_i2c_config_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_config_seq_if.sv
// i2c_config_seq_if
// Bundles the table lookup and the I2C master write-request signals that sit
// between the configuration sequencer and the rest of the codec bring-up path.
//   master modport : the sequencer (drives index, frame fields, write_valid)
//   slave modport  : register table + I2C master (drive cfg_word, write_ready, error)
// Signals:
//   cfg_index      [7:0]  table index currently addressed
//   cfg_word       [15:0] table entry for cfg_index: {reg_addr, data}
//   slav_addr      [6:0]  codec 7-bit I2C address
//   read_not_write        always 0 (writes only)
//   reg_addr       [7:0]  register address for the frame
//   write_data     [7:0]  data byte for the frame
//   write_valid           write request to the I2C master
//   write_ready           I2C master idle/ready
//   error                 I2C master NACK flag
interface i2c_config_seq_if;
  logic [7:0]  cfg_index;
  logic [15:0] cfg_word;
  logic [6:0]  slav_addr;
  logic        read_not_write;
  logic [7:0]  reg_addr;
  logic [7:0]  write_data;
  logic        write_valid;
  logic        write_ready;
  logic        error;

  modport master (
    output cfg_index, slav_addr, read_not_write, reg_addr, write_data, write_valid,
    input  cfg_word, write_ready, error
  );

  modport slave (
    input  cfg_index, slav_addr, read_not_write, reg_addr, write_data, write_valid,
    output cfg_word, write_ready, error
  );
endinterface

// File: rtl/i2c_config_seq.sv
// i2c_config_seq
// Boot-time codec configuration sequencer. Walks a {reg_addr, data} table and
// issues one I2C write per entry to the I2C master, retrying NACKed writes and
// failing on a stuck master.
// Ports:
//   clk          I2C clock (shared with the master)
//   reset        asynchronous, active-high
//   start        one-cycle pulse, starts a run when not busy
//   bus          i2c_config_seq_if.master (table lookup + write handshake)
//   busy         run in progress
//   done         all entries written (sticky until next start)
//   fail         run aborted (sticky until next start)
//   retry_total  saturating retry count for the current run
//
// state      | meaning
// S_IDLE     | waiting for start after reset
// S_SEND     | write_valid high, waiting for write_ready handshake
// S_WAIT_BUSY| frame accepted, waiting for master to drop write_ready
// S_WAIT_DONE| frame on the wire, waiting for write_ready to return
// S_GAP      | idle spacing before the next request
// S_DONE     | all entries written
// S_FAIL     | retries exhausted or master timed out
module i2c_config_seq #(
  parameter int         NUM_REGS       = 11,
  parameter logic [6:0] SLAVE_ADDR     = 7'h1A,
  parameter int         MAX_RETRIES    = 3,
  parameter int         GAP_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  i2c_config_seq_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [7:0]       retry_total
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_DONE, S_FAIL
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);
  localparam logic [7:0]  MAX_RTY  = 8'(MAX_RETRIES);
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit          GAP_SKIP = (GAP_CYCLES == 0);

  state_t      state;
  logic [7:0]  cfg_index;
  logic        write_valid;
  logic [7:0]  retries;
  logic [15:0] tmo_cnt;
  logic [15:0] gap_cnt;

  assign bus.cfg_index      = cfg_index;
  assign bus.write_valid    = write_valid;
  assign bus.slav_addr      = SLAVE_ADDR;
  assign bus.read_not_write = 1'b0;
  assign bus.reg_addr       = bus.cfg_word[15:8];
  assign bus.write_data     = bus.cfg_word[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cfg_index   <= '0;
      write_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      retry_total <= '0;
      retries     <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state       <= S_SEND;
            cfg_index   <= '0;
            retries     <= '0;
            retry_total <= '0;
            done        <= 1'b0;
            fail        <= 1'b0;
            write_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end

        // No timeout here: after a reset mid-frame the master may still be
        // finishing a frame, and we must simply wait for it.
        S_SEND: begin
          if (bus.write_ready) begin
            state       <= S_WAIT_BUSY;
            write_valid <= 1'b0;
            tmo_cnt     <= TMO_LOAD;
          end
        end

        // One timeout budget covers both wait states together.
        S_WAIT_BUSY: begin
          if (!bus.write_ready) begin
            state <= S_WAIT_DONE;
            if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 16'd1;
          end else if (tmo_cnt == '0) begin
            state <= S_FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
          end
        end

        // error is only valid in the first cycle write_ready is back high.
        S_WAIT_DONE: begin
          if (bus.write_ready) begin
            if (!bus.error) begin
              retries <= '0;
              if (cfg_index == LAST_IDX) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                cfg_index <= cfg_index + 8'd1;
                if (GAP_SKIP) begin
                  state       <= S_SEND;
                  write_valid <= 1'b1;
                end else begin
                  state   <= S_GAP;
                  gap_cnt <= GAP_LOAD;
                end
              end
            end else if (retries < MAX_RTY) begin
              retries <= retries + 8'd1;
              if (retry_total != 8'hFF) retry_total <= retry_total + 8'd1;
              if (GAP_SKIP) begin
                state       <= S_SEND;
                write_valid <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              state <= S_FAIL;
              fail  <= 1'b1;
              busy  <= 1'b0;
            end
          end else if (tmo_cnt == '0) begin
            state <= S_FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            state       <= S_SEND;
            write_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        default: begin
          state       <= S_IDLE;
          write_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_seq.sv
module tb_i2c_config_seq;
  localparam int N    = 3;
  localparam int MAXR = 3;
  localparam int GAP  = 2;
  localparam int TMO  = 64;

  typedef struct {
    logic [7:0] ra;
    logic [7:0] wd;
  } xact_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [7:0] retry_total;

  i2c_config_seq_if bus();

  logic [15:0] tbl [256];
  assign bus.cfg_word = tbl[bus.cfg_index];

  i2c_config_seq #(
    .NUM_REGS(N), .SLAVE_ADDR(7'h1A), .MAX_RETRIES(MAXR),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .fail(fail), .retry_total(retry_total)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard / reference-model state
  xact_t exp_q[$];
  logic  err_q[$];
  bit    plan [N][MAXR+1];
  bit    exp_done, exp_fail;
  int    exp_idx, exp_rt;

  // master-model state
  int   frame_len = 30;
  int   mode = 0;        // 0 normal, 1 ready never falls, 2 ready never returns
  bit   m_clear = 0;
  bit   m_busy = 0;
  int   m_cnt = 0;
  logic m_err = 1'b0;
  bit   hs = 0;
  int   hs_cyc = 0;
  int   done_cyc = 0;
  bit   pending = 0;
  logic prev_wv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Expected transactions straight from the rules: each entry is resent
  // while NACKed, up to MAX retries; exhausting them aborts the run.
  task automatic build_model();
    int total;
    bit stop;
    total = 0; stop = 0;
    exp_done = 1; exp_fail = 0; exp_idx = N - 1;
    exp_q.delete(); err_q.delete();
    for (int i = 0; i < N && !stop; i++) begin
      for (int a = 0; a <= MAXR; a++) begin
        exp_q.push_back('{tbl[i][15:8], tbl[i][7:0]});
        err_q.push_back(plan[i][a]);
        if (!plan[i][a]) break;
        if (a == MAXR) begin
          stop = 1; exp_done = 0; exp_fail = 1; exp_idx = i;
          break;
        end
        total = (total < 255) ? total + 1 : 255;
      end
    end
    exp_rt = total;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < N; i++)
      for (int a = 0; a <= MAXR; a++) plan[i][a] = 0;
  endtask

  // I2C master model: drops write_ready for frame_len cycles after each
  // accepted request, then returns it with the planned NACK for one cycle.
  initial begin
    bus.write_ready = 1'b1;
    bus.error = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.write_valid && bus.write_ready;
      @(posedge clk);
      #1;
      bus.error = 1'b0;
      if (m_clear) begin
        m_clear = 0; m_busy = 0; mode = 0;
        bus.write_ready = 1'b1;
      end else if (hs) begin
        hs_cyc = cyc;
        m_err = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
        if (mode != 1) begin
          m_busy = 1; m_cnt = frame_len;
          bus.write_ready = 1'b0;
        end
      end else if (m_busy && mode != 2) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.write_ready = 1'b1;
          bus.error = m_err;
          m_busy = 0;
          pending = 1;
          done_cyc = cyc;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks frame spacing.
  initial begin
    xact_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.write_valid && bus.write_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL hs_unexpected: got reg %0h data %0h expected no handshake",
                     bus.reg_addr, bus.write_data);
          end else begin
            x = exp_q.pop_front();
            chk("hs_reg_addr", 32'(bus.reg_addr), 32'(x.ra));
            chk("hs_write_data", 32'(bus.write_data), 32'(x.wd));
            chk("hs_slav_addr", 32'(bus.slav_addr), 32'h1A);
            chk("hs_rnw", 32'(bus.read_not_write), 32'd0);
          end
        end
        if (bus.write_valid && !prev_wv && pending) begin
          chk("gap_cycles", 32'(cyc - done_cyc), 32'(GAP + 1));
          pending = 0;
        end
      end
      prev_wv = bus.write_valid;
    end
  end

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    pending = 0;
    @(negedge clk);
    start = 1'b0;
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_fail_clr", 32'(fail), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_index", 32'(bus.cfg_index), 32'd0);
    chk("start_rt_clr", 32'(retry_total), 32'd0);
  endtask

  task automatic finish_run(input bit random_starts);
    int k;
    k = 0;
    while (!(done || fail) && k < 20000) begin
      @(negedge clk);
      k++;
      if (random_starts && busy && $urandom_range(0, 30) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (!(done || fail)) bound_fail("run_end");
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_fail", 32'(fail), 32'(exp_fail));
    chk("end_index", 32'(bus.cfg_index), 32'(exp_idx));
    chk("end_retry_total", 32'(retry_total), 32'(exp_rt));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_write_valid", 32'(bus.write_valid), 32'd0);
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stuck_run(input int m, input string nm);
    int k;
    exp_q.delete(); err_q.delete();
    exp_q.push_back('{tbl[0][15:8], tbl[0][7:0]});
    err_q.push_back(1'b0);
    mode = m;
    launch();
    k = 0;
    while (!fail && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!fail) bound_fail(nm);
    chk(nm, 32'(cyc - hs_cyc), 32'(TMO));
    chk("stuck_done", 32'(done), 32'd0);
    chk("stuck_index", 32'(bus.cfg_index), 32'd0);
    chk("stuck_busy", 32'(busy), 32'd0);
    chk("stuck_sb_empty", 32'(exp_q.size()), 32'd0);
    m_clear = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) tbl[i] = 16'h0;
    clear_plan();

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_retry_total", 32'(retry_total), 32'd0);
    chk("rst_index", 32'(bus.cfg_index), 32'd0);
    chk("rst_write_valid", 32'(bus.write_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic run
    tbl[0] = 16'h1E00; tbl[1] = 16'h0C00; tbl[2] = 16'h1201;
    frame_len = 30;
    build_model(); launch(); finish_run(0);

    // single NACK on entry 1 (restarts from DONE)
    clear_plan(); plan[1][0] = 1;
    build_model(); launch(); finish_run(0);

    // persistent NACK on entry 2
    clear_plan();
    for (int a = 0; a <= MAXR; a++) plan[2][a] = 1;
    build_model(); launch(); finish_run(0);

    // randomized runs with stray start pulses
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) tbl[i] = 16'($urandom);
      for (int i = 0; i < N; i++)
        for (int a = 0; a <= MAXR; a++) plan[i][a] = ($urandom_range(0, 2) == 0);
      frame_len = $urandom_range(2, 40);
      build_model(); launch(); finish_run(1);
    end

    // stuck master
    frame_len = 30;
    stuck_run(1, "tmo_ready_high");
    stuck_run(2, "tmo_ready_low");

    // reset during WAIT_DONE of entry 1
    clear_plan();
    build_model(); launch();
    k = 0;
    while (!(bus.cfg_index == 8'd1 && !bus.write_ready && busy) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!(bus.cfg_index == 8'd1 && !bus.write_ready)) bound_fail("reach_entry1");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_write_valid", 32'(bus.write_valid), 32'd0);
    chk("mid_rst_index", 32'(bus.cfg_index), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_fail", 32'(fail), 32'd0);
    chk("mid_rst_retry_total", 32'(retry_total), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    build_model();
    launch();
    @(negedge clk);
    if (m_busy) chk("hold_valid_while_master_busy", 32'(bus.write_valid), 32'd1);
    finish_run(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
